// File: rtl/alu_ctrl.sv
// Accumulator command sequencer driving an external combinational 8-bit ALU; MUL is shift-add over repeated ADDs.
// Latency: ALU/CLR/illegal response 1 cycle after accept, MUL response 9 cycles after accept.
// Backpressure: one command outstanding; cmd_ready low until the response transfers, rsp_* held while stalled.
module alu_ctrl #(
    parameter int MUL_STEPS = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       cmd_valid,
    output logic       cmd_ready,
    input  logic [3:0] cmd_op,
    input  logic [7:0] cmd_data,
    output logic       rsp_valid,
    input  logic       rsp_ready,
    output logic [7:0] rsp_data,
    output logic       rsp_carry,
    output logic       rsp_err,
    output logic [7:0] acc,
    output logic [7:0] alu_x,
    output logic [7:0] alu_y,
    output logic [3:0] alu_op,
    input  logic [7:0] alu_out,
    input  logic       alu_carry
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_MUL,
        S_RESP
    } state_t;

    localparam logic [3:0] OP_ADD  = 4'h4;
    localparam logic [3:0] OP_MUL  = 4'h8;
    localparam logic [3:0] OP_CLR  = 4'h9;
    localparam logic [3:0] OP_SHL  = 4'hF;
    localparam logic [2:0] CNT_LAST = 3'(MUL_STEPS - 1);

    state_t     state, state_nxt;
    logic [7:0] hi, lo, mc;
    logic [2:0] cnt;
    logic [8:0] sum;
    logic [7:0] hi_nxt, lo_nxt;
    logic       accept;
    logic       is_alu_op;

    assign accept    = (state == S_IDLE) && cmd_valid;
    assign is_alu_op = (cmd_op <= 4'h7) || (cmd_op == OP_SHL);

    // One shift-add step: the ALU forms hi+mc, used only when the current multiplier bit is set.
    always_comb begin
        sum    = lo[0] ? {alu_carry, alu_out} : {1'b0, hi};
        hi_nxt = sum[8:1];
        lo_nxt = {sum[0], lo[7:1]};
    end

    always_comb begin
        state_nxt = state;
        cmd_ready = 1'b0;
        rsp_valid = 1'b0;
        alu_x     = acc;
        alu_y     = 8'h00;
        alu_op    = 4'h0;
        case (state)
            S_IDLE: begin
                cmd_ready = 1'b1;
                alu_y     = cmd_data;
                alu_op    = cmd_op;
                if (cmd_valid) begin
                    state_nxt = (cmd_op == OP_MUL) ? S_MUL : S_RESP;
                end
            end
            S_MUL: begin
                alu_x  = hi;
                alu_y  = mc;
                alu_op = OP_ADD;
                if (cnt == CNT_LAST) begin
                    state_nxt = S_RESP;
                end
            end
            S_RESP: begin
                rsp_valid = 1'b1;
                if (rsp_ready) begin
                    state_nxt = S_IDLE;
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc       <= 8'h00;
            rsp_data  <= 8'h00;
            rsp_carry <= 1'b0;
            rsp_err   <= 1'b0;
            hi        <= 8'h00;
            lo        <= 8'h00;
            mc        <= 8'h00;
            cnt       <= 3'd0;
        end else if (accept) begin
            if (is_alu_op) begin
                acc       <= alu_out;
                rsp_data  <= alu_out;
                rsp_carry <= alu_carry;
                rsp_err   <= 1'b0;
            end else if (cmd_op == OP_MUL) begin
                lo  <= acc;
                hi  <= 8'h00;
                mc  <= cmd_data;
                cnt <= 3'd0;
            end else if (cmd_op == OP_CLR) begin
                acc       <= 8'h00;
                rsp_data  <= 8'h00;
                rsp_carry <= 1'b0;
                rsp_err   <= 1'b0;
            end else begin
                rsp_data  <= acc;
                rsp_carry <= 1'b0;
                rsp_err   <= 1'b1;
            end
        end else if (state == S_MUL) begin
            hi  <= hi_nxt;
            lo  <= lo_nxt;
            cnt <= cnt + 3'd1;
            // Final step: low byte becomes the result, any high byte flags overflow.
            if (cnt == CNT_LAST) begin
                acc       <= lo_nxt;
                rsp_data  <= lo_nxt;
                rsp_carry <= (hi_nxt != 8'h00);
                rsp_err   <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_alu_ctrl.sv
// Directed bench for alu_ctrl with a behavioural model of the external 8-bit ALU.
module tb_alu_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic       cmd_valid;
    logic       cmd_ready;
    logic [3:0] cmd_op;
    logic [7:0] cmd_data;
    logic       rsp_valid;
    logic       rsp_ready;
    logic [7:0] rsp_data;
    logic       rsp_carry;
    logic       rsp_err;
    logic [7:0] acc;
    logic [7:0] alu_x, alu_y;
    logic [3:0] alu_op;
    logic [7:0] alu_out;
    logic       alu_carry;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    alu_ctrl dut (
        .clk       (clk),
        .rst       (rst),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_op    (cmd_op),
        .cmd_data  (cmd_data),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_data  (rsp_data),
        .rsp_carry (rsp_carry),
        .rsp_err   (rsp_err),
        .acc       (acc),
        .alu_x     (alu_x),
        .alu_y     (alu_y),
        .alu_op    (alu_op),
        .alu_out   (alu_out),
        .alu_carry (alu_carry)
    );

    // Reference ALU: x is the accumulator side, y the operand; carry on subtract means no borrow.
    always_comb begin
        alu_out   = 8'h00;
        alu_carry = 1'b0;
        case (alu_op)
            4'h0: alu_out = alu_y;
            4'h1: alu_out = alu_x | alu_y;
            4'h2: alu_out = alu_x & alu_y;
            4'h3: alu_out = alu_x ^ alu_y;
            4'h4: {alu_carry, alu_out} = {1'b0, alu_x} + {1'b0, alu_y};
            4'h5: begin alu_out = alu_x - alu_y; alu_carry = (alu_x >= alu_y); end
            4'h6: begin alu_out = {1'b0, alu_x[7:1]}; alu_carry = alu_x[0]; end
            4'h7: begin alu_out = alu_y - alu_x; alu_carry = (alu_y >= alu_x); end
            4'hF: begin alu_out = {alu_x[6:0], 1'b0}; alu_carry = alu_x[7]; end
            default: ;
        endcase
    end

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Issue one command, measure latency to rsp_valid, check the response, then consume it.
    task automatic do_cmd(input string tag, input logic [3:0] op, input logic [7:0] data,
                          input logic [7:0] e_data, input logic e_c, input logic e_err,
                          input int e_lat);
        int lat;
        @(negedge clk);
        cmd_valid = 1'b1;
        cmd_op    = op;
        cmd_data  = data;
        rsp_ready = 1'b1;
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
        cmd_data  = 8'hEE;
        lat = 1;
        while (!rsp_valid && lat < 20) begin
            @(posedge clk);
            #1;
            lat++;
        end
        chk({tag, ".lat"}, 16'(lat), 16'(e_lat));
        chk({tag, ".data"}, {8'h0, rsp_data}, {8'h0, e_data});
        chk({tag, ".carry"}, {15'h0, rsp_carry}, {15'h0, e_c});
        chk({tag, ".err"}, {15'h0, rsp_err}, {15'h0, e_err});
        @(posedge clk);
        #1;
        chk({tag, ".acc"}, {8'h0, acc}, {8'h0, e_data});
        chk({tag, ".done"}, {14'h0, rsp_valid, cmd_ready}, 16'h0001);
    endtask

    initial begin
        rst       = 1'b1;
        cmd_valid = 1'b0;
        cmd_op    = 4'h0;
        cmd_data  = 8'h00;
        rsp_ready = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("rst.acc", {8'h0, acc}, 16'h0000);
        chk("rst.cmd_ready", {15'h0, cmd_ready}, 16'h0001);
        chk("rst.rsp_valid", {15'h0, rsp_valid}, 16'h0000);
        chk("rst.rsp", {6'h0, rsp_data, rsp_carry, rsp_err}, 16'h0000);

        do_cmd("assign5a", 4'h0, 8'h5A, 8'h5A, 1'b0, 1'b0, 1);
        do_cmd("add_b0",   4'h4, 8'hB0, 8'h0A, 1'b1, 1'b0, 1);
        do_cmd("assign03", 4'h0, 8'h03, 8'h03, 1'b0, 1'b0, 1);
        do_cmd("sub_xy",   4'h5, 8'h05, 8'hFE, 1'b0, 1'b0, 1);
        do_cmd("shl",      4'hF, 8'h00, 8'hFC, 1'b1, 1'b0, 1);
        do_cmd("shr",      4'h6, 8'h00, 8'h7E, 1'b0, 1'b0, 1);
        do_cmd("or",       4'h1, 8'h81, 8'hFF, 1'b0, 1'b0, 1);
        do_cmd("and",      4'h2, 8'h3C, 8'h3C, 1'b0, 1'b0, 1);
        do_cmd("xor",      4'h3, 8'hFF, 8'hC3, 1'b0, 1'b0, 1);
        do_cmd("sub_yx",   4'h7, 8'hC4, 8'h01, 1'b1, 1'b0, 1);

        do_cmd("assign0f", 4'h0, 8'h0F, 8'h0F, 1'b0, 1'b0, 1);
        do_cmd("mul_0d",   4'h8, 8'h0D, 8'hC3, 1'b0, 1'b0, 9);
        do_cmd("assign10", 4'h0, 8'h10, 8'h10, 1'b0, 1'b0, 1);
        do_cmd("mul_20",   4'h8, 8'h20, 8'h00, 1'b1, 1'b0, 9);
        do_cmd("assignff", 4'h0, 8'hFF, 8'hFF, 1'b0, 1'b0, 1);
        do_cmd("mul_ff",   4'h8, 8'hFF, 8'h01, 1'b1, 1'b0, 9);

        // Backpressure: ADD stalls 5 cycles while a second command waits on cmd_valid.
        do_cmd("assign01", 4'h0, 8'h01, 8'h01, 1'b0, 1'b0, 1);
        @(negedge clk);
        rsp_ready = 1'b0;
        cmd_valid = 1'b1;
        cmd_op    = 4'h4;
        cmd_data  = 8'h02;
        @(posedge clk);
        #1;
        cmd_op   = 4'h0;
        cmd_data = 8'h77;
        for (int i = 0; i < 5; i++) begin
            chk("bp.hold", {6'h0, rsp_data, rsp_carry, rsp_err}, {6'h0, 8'h03, 2'b00});
            chk("bp.flags", {13'h0, rsp_valid, cmd_ready, 1'b0}, 16'h0004);
            chk("bp.acc", {8'h0, acc}, 16'h0003);
            @(posedge clk);
            #1;
        end
        @(negedge clk);
        rsp_ready = 1'b1;
        @(posedge clk);
        #1;
        chk("bp.release", {14'h0, rsp_valid, cmd_ready}, 16'h0001);
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
        chk("bp.second", {7'h0, rsp_valid, rsp_data}, {7'h0, 1'b1, 8'h77});
        @(posedge clk);
        #1;
        chk("bp.second_acc", {8'h0, acc}, 16'h0077);

        do_cmd("assign33", 4'h0, 8'h33, 8'h33, 1'b0, 1'b0, 1);
        do_cmd("illegal_b", 4'hB, 8'h99, 8'h33, 1'b0, 1'b1, 1);
        do_cmd("clr",      4'h9, 8'h55, 8'h00, 1'b0, 1'b0, 1);

        // Reset during MUL: response discarded, block idle with cleared accumulator.
        do_cmd("assign05", 4'h0, 8'h05, 8'h05, 1'b0, 1'b0, 1);
        @(negedge clk);
        cmd_valid = 1'b1;
        cmd_op    = 4'h8;
        cmd_data  = 8'h03;
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
        repeat (4) @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        chk("mrst.async", {7'h0, rsp_valid, cmd_ready, acc}, {7'h0, 1'b0, 1'b1, 8'h00});
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk);
            #1;
            if (rsp_valid) break;
        end
        chk("mrst.no_rsp", {7'h0, rsp_valid, cmd_ready, acc}, {7'h0, 1'b0, 1'b1, 8'h00});
        do_cmd("post_rst", 4'h0, 8'h01, 8'h01, 1'b0, 1'b0, 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
